// File: rtl/spi_burst_ram_pkg.sv
// Shared types and helpers for the SPI burst RAM.
//   state_t  : frame FSM states
//   OP_WRITE : burst write opcode
//   OP_READ  : burst read opcode (2'b1x is reserved)
//   addr_inc : modulo-depth address increment, valid for non-power-of-two depths
package spi_burst_ram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RD_DUMMY,
    ST_READ,
    ST_WRITE,
    ST_IGNORE
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;

  function automatic logic [31:0] addr_inc(input logic [31:0] a, input logic [31:0] depth);
    return (a == depth - 32'd1) ? '0 : a + 32'd1;
  endfunction

endpackage

// File: rtl/spi_burst_ram_mem.sv
// MEM_DEPTH x DATA_WIDTH word array, synchronous write and synchronous read,
// no reset so it stays inferable as block RAM.
//   clk     : system clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address (out-of-range addresses leave rdata_o unchanged)
//   rdata_o : registered read data
module spi_burst_ram_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i[IW-1:0]] <= wdata_i;
    if (32'(raddr_i) < 32'(MEM_DEPTH)) rdata_q <= mem_q[raddr_i[IW-1:0]];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_burst_ram.sv
// SPI-slave burst memory. One frame = 2-bit opcode, ADDR_WIDTH-bit start
// address, then an unbounded stream of DATA_WIDTH-bit words with modulo
// address auto-increment. All SPI pins are sampled on clk.
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   SS_n      : slave select, active low
//   MOSI      : serial in, MSB first
//   MISO      : registered serial out, MSB first
//   frame_err : one-cycle pulse on reserved opcode or out-of-range start address
module spi_burst_ram
  import spi_burst_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic frame_err
);

  localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic                  miso_q, miso_d;
  logic                  err_q, err_d;

  logic [ADDR_WIDTH-1:0] addr_shift;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [DATA_WIDTH-1:0] rx_word;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  addr_bad;
  logic                  we;

  assign addr_shift = ADDR_WIDTH'({addr_q, MOSI});
  assign rx_word    = DATA_WIDTH'({rx_q, MOSI});
  assign addr_bad   = (32'(addr_shift) >= 32'(MEM_DEPTH));
  assign addr_next  = ADDR_WIDTH'(addr_inc(32'(addr_q), 32'(MEM_DEPTH)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (SS_n) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     state_d = ST_CMD;
        ST_CMD:      state_d = ST_ADDR;
        ST_ADDR: begin
          if (cnt_q == ADDR_LAST) begin
            if (op_q[1] || addr_bad)  state_d = ST_IGNORE;
            else if (op_q == OP_READ) state_d = ST_RD_DUMMY;
            else                      state_d = ST_WRITE;
          end
        end
        ST_RD_DUMMY: state_d = ST_READ;
        ST_READ, ST_WRITE, ST_IGNORE: state_d = state_q;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // The read port always fetches mem[addr_d], so rd_data holds the word at
  // addr_q one cycle later. RD_DUMMY behaves like a READ edge with cnt==0:
  // it loads that word, sends its MSB and advances the address, which makes
  // consecutive words stream without a gap.
  always_comb begin
    cnt_d  = cnt_q;
    addr_d = addr_q;
    op_d   = op_q;
    rx_d   = rx_q;
    tx_d   = tx_q;
    miso_d = 1'b0;
    err_d  = 1'b0;
    we     = 1'b0;
    if (SS_n) begin
      cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_CMD: op_d = {op_q[0], MOSI};
        ST_ADDR: begin
          addr_d = addr_shift;
          if (cnt_q == ADDR_LAST) begin
            cnt_d = '0;
            err_d = op_q[1] || addr_bad;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_WRITE: begin
          rx_d = rx_word;
          if (cnt_q == DATA_LAST) begin
            we     = 1'b1;
            addr_d = addr_next;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RD_DUMMY, ST_READ: begin
          if (cnt_q == '0) begin
            miso_d = rd_data[DATA_WIDTH-1];
            tx_d   = rd_data << 1;
            addr_d = addr_next;
          end else begin
            miso_d = tx_q[DATA_WIDTH-1];
            tx_d   = tx_q << 1;
          end
          cnt_d = (cnt_q == DATA_LAST) ? '0 : cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      addr_q <= '0;
      op_q   <= '0;
      rx_q   <= '0;
      tx_q   <= '0;
      miso_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      op_q   <= op_d;
      rx_q   <= rx_d;
      tx_q   <= tx_d;
      miso_q <= miso_d;
      err_q  <= err_d;
    end
  end

  assign MISO      = miso_q;
  assign frame_err = err_q;

  spi_burst_ram_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk    (clk),
    .we_i   (we),
    .waddr_i(addr_q),
    .wdata_i(rx_word),
    .raddr_i(addr_d),
    .rdata_o(rd_data)
  );

endmodule

// File: tb/tb_spi_burst_ram.sv
// Directed bench for spi_burst_ram: a 256-deep and a 200-deep instance share
// clk/rst_n/MOSI with separate slave selects. Read frames push expected words
// from a reference memory model into a queue; reassembled MISO words pop it.
module tb_spi_burst_ram;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ss0 = 1'b1;
  logic ss1 = 1'b1;
  logic mosi = 1'b0;
  logic miso0, fe0, miso1, fe1;

  always #5 clk = ~clk;

  spi_burst_ram dut (
    .clk(clk), .rst_n(rst_n), .SS_n(ss0), .MOSI(mosi), .MISO(miso0), .frame_err(fe0)
  );

  spi_burst_ram #(
    .DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(200)
  ) dut200 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss1), .MOSI(mosi), .MISO(miso1), .frame_err(fe1)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [7:0] model0 [256];
  logic [7:0] model1 [200];
  logic [7:0] exp_q [$];
  logic [7:0] payload [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ss(input int which, input logic v);
    if (which == 1) ss1 = v;
    else            ss0 = v;
  endtask

  // Caller is positioned at a negedge; the frame starts driving immediately
  // and returns at a negedge after exactly one SS_n-high edge.
  task automatic frame(input int which, input logic [1:0] op, input logic [7:0] addr,
                       input int nbits, input int abort_at, input string tag);
    int depth;
    bit bad, rd;
    int nfull, n, idx, p, k, fe_cnt, fe_at, popped, nexp;
    bit nz, aborted;
    logic m, f;
    logic [7:0] cur, w;
    depth   = (which == 1) ? 200 : 256;
    bad     = op[1] || (int'(addr) >= depth);
    rd      = !bad && (op == 2'b01);
    nfull   = nbits / 8;
    n       = 10 + nbits;
    fe_cnt  = 0;
    fe_at   = -1;
    popped  = 0;
    nz      = 0;
    aborted = 0;
    cur     = '0;
    nexp    = rd ? nfull : 0;
    if (rd) begin
      for (int i = 0; i < nfull; i++) begin
        k = (int'(addr) + i) % depth;
        exp_q.push_back((which == 1) ? model1[k] : model0[k]);
      end
    end
    for (int e = 0; e <= n; e++) begin
      if (e > 0) begin
        @(negedge clk);
        idx = e - 1;
        m = (which == 1) ? miso1 : miso0;
        f = (which == 1) ? fe1 : fe0;
        if (f) begin
          fe_cnt++;
          fe_at = idx;
        end
        if (rd && idx >= 10) begin
          cur = {cur[6:0], m};
          if ((idx - 10) % 8 == 7) begin
            popped++;
            if (exp_q.size() > 0) begin
              check({tag, "_word"}, 32'(cur), 32'(exp_q.pop_front()));
            end else begin
              checks++;
              errors++;
              $error("FAIL %s_extra observed=%0h expected=none", tag, cur);
            end
          end
        end else if (m) begin
          nz = 1;
        end
      end
      if (abort_at >= 0 && e - 1 == abort_at) begin
        rst_n = 1'b0;
        #1;
        check({tag, "_miso_at_reset"}, 32'((which == 1) ? miso1 : miso0), 32'd0);
        check({tag, "_err_at_reset"}, 32'((which == 1) ? fe1 : fe0), 32'd0);
        set_ss(which, 1'b1);
        aborted = 1;
        break;
      end
      if (e == n) begin
        set_ss(which, 1'b1);
        mosi = 1'b0;
      end else begin
        set_ss(which, 1'b0);
        if (e < 2)       mosi = op[1-e];
        else if (e < 10) mosi = addr[7-(e-2)];
        else begin
          p = e - 10;
          k = p / 8;
          if (k < payload.size()) begin
            w = payload[k];
            mosi = w[7-(p%8)];
          end else begin
            mosi = 1'b0;
          end
        end
      end
    end
    if (aborted) begin
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
    end else begin
      @(negedge clk);
      check({tag, "_miso_idle"}, 32'((which == 1) ? miso1 : miso0), 32'd0);
      check({tag, "_err_count"}, 32'(fe_cnt), bad ? 32'd1 : 32'd0);
      check({tag, "_err_edge"}, 32'(fe_at), bad ? 32'd9 : 32'hFFFF_FFFF);
      check({tag, "_miso_quiet"}, 32'(nz), 32'd0);
      check({tag, "_words"}, 32'(popped), 32'(nexp));
      if (!bad && op == 2'b00) begin
        for (int i = 0; i < nfull; i++) begin
          k = (int'(addr) + i) % depth;
          if (which == 1) model1[k] = payload[i];
          else            model0[k] = payload[i];
        end
      end
    end
    exp_q.delete();
    payload.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_miso0", 32'(miso0), 32'd0);
    check("reset_err0", 32'(fe0), 32'd0);
    check("reset_miso1", 32'(miso1), 32'd0);
    check("reset_err1", 32'(fe1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // burst write and gapless read-back
    payload = '{8'hA5, 8'h3C, 8'hFF};
    frame(0, 2'b00, 8'h10, 24, -1, "wr_burst");
    frame(0, 2'b01, 8'h10, 24, -1, "rd_burst");

    // wrap-around at the top of a 256-word array
    payload = '{8'h11, 8'h22};
    frame(0, 2'b00, 8'hFF, 16, -1, "wr_wrap");
    frame(0, 2'b01, 8'hFF, 16, -1, "rd_wrap");
    frame(0, 2'b01, 8'h00, 8, -1, "rd_addr0");

    // partial word is discarded
    payload = '{8'h5A};
    frame(0, 2'b00, 8'h20, 8, -1, "wr_0x20");
    payload = '{8'hC3};
    frame(0, 2'b00, 8'h20, 5, -1, "wr_partial");
    frame(0, 2'b01, 8'h20, 8, -1, "rd_0x20");

    // reserved opcodes: error pulse, no access
    payload = '{8'h77};
    frame(0, 2'b00, 8'h05, 8, -1, "wr_0x05");
    payload = '{8'hEE, 8'hDD};
    frame(0, 2'b11, 8'h05, 16, -1, "op_11");
    frame(0, 2'b01, 8'h05, 8, -1, "rd_0x05");
    frame(0, 2'b10, 8'h10, 8, -1, "op_10");

    // non-power-of-two depth
    payload = '{8'h99, 8'h66};
    frame(1, 2'b00, 8'hC7, 16, -1, "d200_wr");
    frame(1, 2'b01, 8'hC7, 16, -1, "d200_rd");
    frame(1, 2'b01, 8'h00, 8, -1, "d200_rd0");
    payload = '{8'h44};
    frame(1, 2'b00, 8'hC8, 8, -1, "d200_oor");
    frame(1, 2'b01, 8'hC7, 8, -1, "d200_rd_after");

    // reset during word 1 bit 3 of a read, then a clean read
    frame(0, 2'b01, 8'h10, 24, 21, "rd_reset");
    frame(0, 2'b01, 8'h10, 8, -1, "rd_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
